// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - eight-input prioritised Z80 interrupt controller with mode-0/mode-2 vectoring
module intr_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_req,
    input  logic            eoi,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic [7:0]      cfg_rdata,
    output logic            INT,
    input  logic            M1,
    input  logic            IORQ,
    inout  wire  [7:0]      Data
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t          state, state_next;
    logic [NSRC-1:0] prev, pend, isr, mask, cand, edges, w1c, win_bit, eoi_clr;
    logic [7:0]      vbase, vec, vec_next;
    logic            mode0;
    logic [2:0]      win, top;
    logic            eligible, ack, latch, take;

    assign ack   = !M1 && !IORQ;
    assign edges = irq_req & ~prev;
    assign cand  = pend & ~mask;
    assign w1c   = (cfg_we && cfg_addr == 3'd3) ? cfg_wdata : '0;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        win = '0;
        top = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) win = 3'(i);
            if (isr[i])  top = 3'(i);
        end
    end

    assign eligible = (cand != '0) && (isr == '0 || win < top);

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (ack) begin
                    state_next = ACK;
                    latch      = 1'b1;
                end
            end
            ACK: begin
                if (!ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign take    = latch && eligible;
    assign win_bit = take ? (NSRC'(1) << win) : '0;
    assign eoi_clr = (eoi && isr != '0) ? (NSRC'(1) << top) : '0;

    always_comb begin
        vec_next = 8'hFF;
        if (eligible) begin
            if (mode0) vec_next = 8'hC7 | {2'b00, win, 3'b000};
            else       vec_next = {vbase[7:4], win, 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prev  <= '0;
            pend  <= '0;
            isr   <= '0;
            vec   <= '0;
            INT   <= 1'b1;
            mask  <= '1;
            vbase <= '0;
            mode0 <= 1'b0;
        end else begin
            state <= state_next;
            prev  <= irq_req;
            // A fresh edge outranks both W1C and the acknowledge clear.
            pend  <= (pend & ~w1c & ~win_bit) | edges;
            isr   <= (isr & ~eoi_clr) | win_bit;
            if (latch) vec <= vec_next;
            INT   <= ~(eligible && state_next == IDLE);
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0:    mask  <= cfg_wdata;
                    3'd1:    vbase <= cfg_wdata;
                    3'd2:    mode0 <= cfg_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = 8'h00;
        case (cfg_addr)
            3'd0:    cfg_rdata = mask;
            3'd1:    cfg_rdata = vbase;
            3'd2:    cfg_rdata = {7'b0, mode0};
            3'd3:    cfg_rdata = pend;
            3'd4:    cfg_rdata = isr;
            default: cfg_rdata = 8'h00;
        endcase
    end

    assign Data = (state == ACK && ack) ? vec : 8'hzz;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed bench for intr_ctrl with a reference model and per-cycle compare
module tb_intr_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_req;
    logic       eoi, cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata;
    logic       int_n, m1_n, iorq_n;
    tri   [7:0] data_bus;

    int checks = 0;
    int errors = 0;

    // Released bus reads back as 8'h00.
    for (genvar g = 0; g < 8; g++) begin : g_pd
        pulldown (data_bus[g]);
    end

    intr_ctrl dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .eoi(eoi),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .INT(int_n), .M1(m1_n), .IORQ(iorq_n), .Data(data_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] m_pend, m_isr, m_mask, m_vbase, m_prev, m_vec;
    logic       m_mode0, m_inack, m_int;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_mask;
            3'd1: return m_vbase;
            3'd2: return {7'b0, m_mode0};
            3'd3: return m_pend;
            3'd4: return m_isr;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 0; m_isr = 0; m_prev = 0; m_vec = 0;
            m_mask = 8'hFF; m_vbase = 0; m_mode0 = 0; m_inack = 0; m_int = 1;
        end else begin
            logic [7:0] cand, newpend, newisr;
            int w, t;
            bit elig, acking;
            cand    = m_pend & ~m_mask;
            w       = lowest(cand);
            t       = lowest(m_isr);
            elig    = (w < 8) && (w < t);
            acking  = !m1_n && !iorq_n;
            newpend = m_pend & ~((cfg_we && cfg_addr == 3'd3) ? cfg_wdata : 8'h00);
            newisr  = m_isr;
            if (eoi && t < 8) newisr[t] = 1'b0;
            if (!m_inack && acking) begin
                if (elig) begin
                    newpend[w] = 1'b0;
                    newisr[w]  = 1'b1;
                    m_vec = m_mode0 ? (8'hC7 | 8'(w * 8)) : 8'(m_vbase[7:4] * 16 + w * 2);
                end else begin
                    m_vec = 8'hFF;
                end
            end
            m_int   = !(elig && !acking);
            m_inack = acking;
            m_pend  = newpend | (irq_req & ~m_prev);
            m_isr   = newisr;
            m_prev  = irq_req;
            if (cfg_we && cfg_addr == 3'd0) m_mask  = cfg_wdata;
            if (cfg_we && cfg_addr == 3'd1) m_vbase = cfg_wdata;
            if (cfg_we && cfg_addr == 3'd2) m_mode0 = cfg_wdata[0];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            logic [7:0] exp_data;
            exp_data = (m_inack && !m1_n && !iorq_n) ? m_vec : 8'h00;
            checks++;
            if (int_n !== m_int) begin
                errors++;
                $display("FAIL model_int t=%0t got %b exp %b", $time, int_n, m_int);
            end
            checks++;
            if (data_bus !== exp_data) begin
                errors++;
                $display("FAIL model_data t=%0t got %h exp %h", $time, data_bus, exp_data);
            end
            checks++;
            if (cfg_rdata !== m_read(cfg_addr)) begin
                errors++;
                $display("FAIL model_rdata addr=%0d t=%0t got %h exp %h", cfg_addr, $time, cfg_rdata, m_read(cfg_addr));
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq_req = v;
        cycle();
        irq_req = 8'h00;
    endtask

    task automatic do_ack(input string name, input logic [7:0] expv);
        m1_n = 1'b0; iorq_n = 1'b0;
        cycle();
        chk({name, "_data0"}, data_bus, expv);
        chk({name, "_int"}, {7'b0, int_n}, 8'h01);
        cycle();
        chk({name, "_data1"}, data_bus, expv);
        m1_n = 1'b1;
        #1;
        chk({name, "_release"}, data_bus, 8'h00);
        iorq_n = 1'b1;
        cycle();
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_req = 0; eoi = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        m1_n = 1'b1; iorq_n = 1'b1;
        cycle(); cycle();
        chk("rst_int", {7'b0, int_n}, 8'h01);
        chk("rst_data", data_bus, 8'h00);
        rd_chk("rst_mask", 3'd0, 8'hFF);
        rd_chk("rst_vbase", 3'd1, 8'h00);
        reset = 1'b0;
        cycle();

        // single source, mode 2
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h80);
        pulse_irq(8'h08);
        rd_chk("s1_pend", 3'd3, 8'h08);
        chk("s1_int_hi", {7'b0, int_n}, 8'h01);
        cycle();
        chk("s1_int_lo", {7'b0, int_n}, 8'h00);
        do_ack("s1_ack", 8'h86);
        rd_chk("s1_isr", 3'd4, 8'h08);
        rd_chk("s1_pend0", 3'd3, 8'h00);
        chk("s1_int_after", {7'b0, int_n}, 8'h01);
        eoi_pulse();
        rd_chk("s1_eoi", 3'd4, 8'h00);

        // priority and nesting
        pulse_irq(8'h24);
        cycle();
        chk("p_int_lo", {7'b0, int_n}, 8'h00);
        do_ack("p_ack2", 8'h84);
        rd_chk("p_isr2", 3'd4, 8'h04);
        cycle();
        chk("p_int_blocked", {7'b0, int_n}, 8'h01);
        eoi_pulse();
        cycle();
        chk("p_int_src5", {7'b0, int_n}, 8'h00);
        do_ack("p_ack5", 8'h8A);
        pulse_irq(8'h01);
        cycle();
        chk("p_int_nest", {7'b0, int_n}, 8'h00);
        do_ack("p_ack0", 8'h80);
        rd_chk("p_isr_nest", 3'd4, 8'h21);
        eoi_pulse();
        rd_chk("p_eoi_top", 3'd4, 8'h20);
        eoi_pulse();

        // mode 0
        wr(3'd2, 8'hFF);
        rd_chk("m0_ctrl", 3'd2, 8'h01);
        pulse_irq(8'h80);
        cycle();
        do_ack("m0_rst38", 8'hFF);
        pulse_irq(8'h01);
        cycle();
        do_ack("m0_rst00", 8'hC7);
        rd_chk("m0_isr", 3'd4, 8'h81);
        eoi_pulse();
        eoi_pulse();
        wr(3'd2, 8'h00);

        // masking and W1C
        wr(3'd0, 8'hFF);
        pulse_irq(8'h02);
        rd_chk("w_pend", 3'd3, 8'h02);
        cycle();
        chk("w_int_masked", {7'b0, int_n}, 8'h01);
        wr(3'd3, 8'h02);
        rd_chk("w_clear", 3'd3, 8'h00);
        irq_req = 8'h02;
        wr(3'd3, 8'h02);
        irq_req = 8'h00;
        rd_chk("w_set_wins", 3'd3, 8'h02);
        wr(3'd0, 8'h00);
        chk("w_unmask_edge", {7'b0, int_n}, 8'h01);
        cycle();
        chk("w_unmask_int", {7'b0, int_n}, 8'h00);
        wr(3'd3, 8'h02);
        cycle();
        chk("w_int_drop", {7'b0, int_n}, 8'h01);

        // spurious acknowledge
        do_ack("sp_ack", 8'hFF);
        rd_chk("sp_pend", 3'd3, 8'h00);
        rd_chk("sp_isr", 3'd4, 8'h00);

        // reset mid-acknowledge
        pulse_irq(8'h08);
        cycle();
        m1_n = 1'b0; iorq_n = 1'b0;
        cycle();
        chk("r_data_pre", data_bus, 8'h86);
        #2;
        reset = 1'b1;
        #1;
        chk("r_data_z", data_bus, 8'h00);
        chk("r_int", {7'b0, int_n}, 8'h01);
        rd_chk("r_mask", 3'd0, 8'hFF);
        rd_chk("r_vbase", 3'd1, 8'h00);
        rd_chk("r_pend", 3'd3, 8'h00);
        rd_chk("r_isr", 3'd4, 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        cycle();
        reset = 1'b0;
        cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
